// File: rtl/csi_raw10_unpack_4lane.sv
// csi_raw10_unpack_4lane
// Unpacks the 4-byte/beat CSI payload stream into 4 x 10-bit RAW10 pixels per
// output beat. It also produces line start/end markers, a per-frame line
// counter and a flag for lines that end part-way through a 5-byte group.
module csi_raw10_unpack_4lane #(
    parameter int LINE_CNT_W = 12
) (
    input  logic                  I_clk,
    input  logic                  I_rst_n,
    input  logic                  I_csi_frame_start,
    input  logic                  I_csi_frame_end,
    input  logic                  I_csi_valid,
    input  logic [31:0]           I_csi_data,
    output logic                  O_frame_start,
    output logic                  O_frame_end,
    output logic                  O_line_start,
    output logic                  O_line_end,
    output logic                  O_pix_valid,
    output logic [39:0]           O_pix_data,
    output logic [LINE_CNT_W-1:0] O_line_cnt,
    output logic                  O_line_err
);

    // Phase = number of input beats (mod 5) consumed in the current line.
    typedef enum logic [2:0] {
        PH0 = 3'd0,
        PH1 = 3'd1,
        PH2 = 3'd2,
        PH3 = 3'd3,
        PH4 = 3'd4
    } phase_t;

    phase_t      r_phase;
    phase_t      w_phase_nxt;
    logic [31:0] r_residue;      // leftover bytes, left-justified (oldest in [31:24])
    logic [31:0] w_residue_nxt;
    logic [39:0] w_group;        // 5-byte group, B0 in [39:32]
    logic        w_group_vld;
    logic        r_valid_1d;
    logic        r_line_started;
    logic        r_abort;        // line cut by a frame start; ignore the rest of it
    logic        w_fall;
    logic        w_beat;

    // A 5-byte RAW10 group becomes {P3,P2,P1,P0}. Pi = {Bi, B4[2i+1:2i]}.
    function automatic logic [39:0] unpack_group(input logic [39:0] grp);
        logic [39:0] pix;
        pix = 40'h0;
        for (int i = 0; i < 4; i++) begin
            pix[10*i +: 10] = {grp[39-8*i -: 8], grp[2*i +: 2]};
        end
        return pix;
    endfunction

    assign w_fall = r_valid_1d & ~I_csi_valid;
    assign w_beat = I_csi_valid & ~r_abort & ~I_csi_frame_start;

    // Next phase and residue, and the group completed by this beat.
    always_comb begin
        w_phase_nxt   = r_phase;
        w_residue_nxt = r_residue;
        w_group       = 40'h0;
        w_group_vld   = 1'b0;
        if (I_csi_frame_start || w_fall) begin
            w_phase_nxt   = PH0;
            w_residue_nxt = 32'h0;
        end else if (w_beat) begin
            case (r_phase)
                PH0: begin
                    w_phase_nxt   = PH1;
                    w_residue_nxt = I_csi_data;
                end
                PH1: begin
                    w_phase_nxt   = PH2;
                    w_group       = {r_residue, I_csi_data[31:24]};
                    w_group_vld   = 1'b1;
                    w_residue_nxt = {I_csi_data[23:0], 8'h00};
                end
                PH2: begin
                    w_phase_nxt   = PH3;
                    w_group       = {r_residue[31:8], I_csi_data[31:16]};
                    w_group_vld   = 1'b1;
                    w_residue_nxt = {I_csi_data[15:0], 16'h0000};
                end
                PH3: begin
                    w_phase_nxt   = PH4;
                    w_group       = {r_residue[31:16], I_csi_data[31:8]};
                    w_group_vld   = 1'b1;
                    w_residue_nxt = {I_csi_data[7:0], 24'h000000};
                end
                PH4: begin
                    w_phase_nxt   = PH0;
                    w_group       = {r_residue[31:24], I_csi_data};
                    w_group_vld   = 1'b1;
                    w_residue_nxt = 32'h0;
                end
                default: begin
                    w_phase_nxt   = PH0;
                    w_residue_nxt = 32'h0;
                end
            endcase
        end else begin
            w_phase_nxt   = r_phase;
            w_residue_nxt = r_residue;
        end
    end

    // Phase state and residue bytes.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_phase   <= PH0;
            r_residue <= 32'h0;
        end else begin
            r_phase   <= w_phase_nxt;
            r_residue <= w_residue_nxt;
        end
    end

    // Registered pixel output, line markers, line counter and frame pulses.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_valid_1d     <= 1'b0;
            r_line_started <= 1'b0;
            r_abort        <= 1'b0;
            O_frame_start  <= 1'b0;
            O_frame_end    <= 1'b0;
            O_line_start   <= 1'b0;
            O_line_end     <= 1'b0;
            O_pix_valid    <= 1'b0;
            O_pix_data     <= 40'h0;
            O_line_cnt     <= '0;
            O_line_err     <= 1'b0;
        end else begin
            r_valid_1d    <= I_csi_valid;
            O_frame_start <= I_csi_frame_start;
            O_frame_end   <= I_csi_frame_end;
            O_pix_valid   <= w_group_vld;
            O_line_start  <= w_group_vld & ~r_line_started;
            O_line_end    <= 1'b0;
            O_line_err    <= 1'b0;
            if (w_group_vld) begin
                O_pix_data <= unpack_group(w_group);
            end else begin
                O_pix_data <= O_pix_data;
            end
            if (I_csi_frame_start) begin
                // Frame start wins over a coinciding line end.
                O_line_cnt     <= '0;
                r_line_started <= 1'b0;
                r_abort        <= I_csi_valid;
            end else if (w_fall) begin
                r_line_started <= 1'b0;
                r_abort        <= 1'b0;
                if (!r_abort) begin
                    O_line_end <= 1'b1;
                    O_line_err <= (r_phase != PH0);
                    O_line_cnt <= O_line_cnt + LINE_CNT_W'(1);
                end else begin
                    O_line_cnt <= O_line_cnt;
                end
            end else if (w_group_vld) begin
                r_line_started <= 1'b1;
            end else begin
                r_line_started <= r_line_started;
            end
        end
    end

endmodule

// File: tb/tb_csi_raw10_unpack_4lane.sv
// Scoreboard bench for csi_raw10_unpack_4lane: a byte-queue reference model
// pushes expected pixel beats, line ends and frame pulses with their expected
// cycle; a negedge monitor pops and compares whatever the DUT presents.
module tb_csi_raw10_unpack_4lane;

    logic        I_clk;
    logic        I_rst_n;
    logic        I_csi_frame_start;
    logic        I_csi_frame_end;
    logic        I_csi_valid;
    logic [31:0] I_csi_data;
    logic        O_frame_start;
    logic        O_frame_end;
    logic        O_line_start;
    logic        O_line_end;
    logic        O_pix_valid;
    logic [39:0] O_pix_data;
    logic [11:0] O_line_cnt;
    logic        O_line_err;

    csi_raw10_unpack_4lane #(.LINE_CNT_W(12)) dut (
        .I_clk             (I_clk),
        .I_rst_n           (I_rst_n),
        .I_csi_frame_start (I_csi_frame_start),
        .I_csi_frame_end   (I_csi_frame_end),
        .I_csi_valid       (I_csi_valid),
        .I_csi_data        (I_csi_data),
        .O_frame_start     (O_frame_start),
        .O_frame_end       (O_frame_end),
        .O_line_start      (O_line_start),
        .O_line_end        (O_line_end),
        .O_pix_valid       (O_pix_valid),
        .O_pix_data        (O_pix_data),
        .O_line_cnt        (O_line_cnt),
        .O_line_err        (O_line_err)
    );

    typedef struct {
        int unsigned t;
        logic [39:0] data;
        logic        ls;
    } pix_t;

    typedef struct {
        int unsigned t;
        logic        err;
        logic [11:0] cnt;
    } le_t;

    pix_t        pix_q[$];
    le_t         le_q[$];
    int unsigned fs_q[$];
    int unsigned fe_q[$];

    int          n_checks;
    int          n_fail;
    int unsigned cyc;

    // model state
    logic [7:0]  mq[$];
    logic [11:0] m_cnt;
    logic        m_prev;
    logic        m_abort;
    logic        m_started;

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    always @(posedge I_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cnt     = 12'd0;
        m_prev    = 1'b0;
        m_abort   = 1'b0;
        m_started = 1'b0;
    endtask

    // Reference model: bytes of the current line pile up; every 5 bytes is a group.
    task automatic model_step(input logic fs, input logic fe, input logic v, input logic [31:0] d);
        pix_t        p;
        le_t         l;
        logic [7:0]  b[5];
        logic [39:0] pd;
        if (fs) fs_q.push_back(cyc + 1);
        if (fe) fe_q.push_back(cyc + 1);
        if (fs) begin
            m_cnt     = 12'd0;
            mq.delete();
            m_abort   = v;
            m_started = 1'b0;
        end else if (m_prev && !v) begin
            if (!m_abort) begin
                m_cnt = m_cnt + 12'd1;
                l.t   = cyc + 1;
                l.err = (mq.size() != 0);
                l.cnt = m_cnt;
                le_q.push_back(l);
            end
            mq.delete();
            m_abort   = 1'b0;
            m_started = 1'b0;
        end else if (v && !m_abort) begin
            for (int k = 0; k < 4; k++) mq.push_back(d[31-8*k -: 8]);
            if (mq.size() >= 5) begin
                for (int k = 0; k < 5; k++) b[k] = mq.pop_front();
                for (int i = 0; i < 4; i++) pd[10*i +: 10] = {b[i], b[4][2*i +: 2]};
                p.t       = cyc + 1;
                p.data    = pd;
                p.ls      = !m_started;
                m_started = 1'b1;
                pix_q.push_back(p);
            end
        end
        m_prev = v;
    endtask

    task automatic drive(input logic fs, input logic fe, input logic v, input logic [31:0] d);
        @(negedge I_clk);
        I_csi_frame_start = fs;
        I_csi_frame_end   = fe;
        I_csi_valid       = v;
        I_csi_data        = d;
        model_step(fs, fe, v, d);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, $urandom);
    endtask

    // One line of n beats; optional frame start on beat fs_at or on the fall cycle.
    task automatic send_line(input int n, input int gap, input int fs_at, input logic fs_fall);
        for (int k = 0; k < n; k++) drive(k == fs_at, 1'b0, 1'b1, $urandom);
        for (int g = 0; g < gap; g++) drive((g == 0) && fs_fall, 1'b0, 1'b0, $urandom);
    endtask

    // Monitor: pop and compare whenever the DUT presents an event.
    always @(negedge I_clk) begin
        if (I_rst_n) begin
            if (O_pix_valid) begin
                if (pix_q.size() == 0) begin
                    chk("pix_unexpected", 64'(O_pix_data), 64'h0);
                    chk("pix_unexpected_valid", 64'(O_pix_valid), 64'h0);
                end else begin
                    pix_t p;
                    p = pix_q.pop_front();
                    chk("pix_cycle", 64'(cyc), 64'(p.t));
                    chk("pix_data", 64'(O_pix_data), 64'(p.data));
                    chk("line_start", 64'(O_line_start), 64'(p.ls));
                end
            end else begin
                chk("line_start_idle", 64'(O_line_start), 64'h0);
            end
            if (O_line_end) begin
                if (le_q.size() == 0) begin
                    chk("line_end_unexpected", 64'(O_line_end), 64'h0);
                end else begin
                    le_t l;
                    l = le_q.pop_front();
                    chk("line_end_cycle", 64'(cyc), 64'(l.t));
                    chk("line_err", 64'(O_line_err), 64'(l.err));
                    chk("line_cnt", 64'(O_line_cnt), 64'(l.cnt));
                end
            end else begin
                chk("line_err_idle", 64'(O_line_err), 64'h0);
            end
            if (O_frame_start) begin
                if (fs_q.size() == 0) begin
                    chk("fs_unexpected", 64'(O_frame_start), 64'h0);
                end else begin
                    chk("fs_cycle", 64'(cyc), 64'(fs_q.pop_front()));
                    chk("fs_cnt_zero", 64'(O_line_cnt), 64'h0);
                end
            end
            if (O_frame_end) begin
                if (fe_q.size() == 0) begin
                    chk("fe_unexpected", 64'(O_frame_end), 64'h0);
                end else begin
                    chk("fe_cycle", 64'(cyc), 64'(fe_q.pop_front()));
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_frame_start"}, 64'(O_frame_start), 64'h0);
        chk({tag, "_frame_end"},   64'(O_frame_end),   64'h0);
        chk({tag, "_line_start"},  64'(O_line_start),  64'h0);
        chk({tag, "_line_end"},    64'(O_line_end),    64'h0);
        chk({tag, "_pix_valid"},   64'(O_pix_valid),   64'h0);
        chk({tag, "_pix_data"},    64'(O_pix_data),    64'h0);
        chk({tag, "_line_cnt"},    64'(O_line_cnt),    64'h0);
        chk({tag, "_line_err"},    64'(O_line_err),    64'h0);
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        cyc               = 0;
        I_rst_n           = 1'b0;
        I_csi_frame_start = 1'b0;
        I_csi_frame_end   = 1'b0;
        I_csi_valid       = 1'b0;
        I_csi_data        = 32'h0;
        model_reset();
        repeat (3) @(negedge I_clk);
        chk_all_zero("reset");
        I_rst_n = 1'b1;

        // known group: 0x80402010, 0xE4xxxxxx
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        idle(1);
        drive(1'b0, 1'b0, 1'b1, 32'h80402010);
        drive(1'b0, 1'b0, 1'b1, {8'hE4, 24'($urandom)});
        @(posedge I_clk);
        #1;
        chk("known_valid", 64'(O_pix_valid), 64'h1);
        chk("known_data", 64'(O_pix_data), 64'h10C8240600);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b1, $urandom);
        idle(2);

        send_line(10, 2, -1, 1'b0);  // 8 pixel beats, no error
        send_line(7, 1, -1, 1'b0);   // ends mid-group
        send_line(5, 2, -1, 1'b0);   // fresh from phase 0
        send_line(1, 2, -1, 1'b0);   // single beat line
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        idle(3);
        chk("cnt_after_fe", 64'(O_line_cnt), 64'(m_cnt));

        // frame of 3 lines of 5 beats
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        idle(1);
        for (int k = 0; k < 3; k++) send_line(5, 2, -1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        idle(3);
        chk("cnt_three_lines", 64'(O_line_cnt), 64'd3);

        // frame start in the middle of a line, then on the fall cycle
        send_line(6, 2, 3, 1'b0);
        chk("cnt_after_abort", 64'(O_line_cnt), 64'd0);
        send_line(5, 2, -1, 1'b0);
        send_line(4, 2, -1, 1'b1);
        chk("cnt_fs_on_fall", 64'(O_line_cnt), 64'd0);

        // randomized lines
        for (int n = 0; n < 40; n++) begin
            send_line($urandom_range(1, 13), $urandom_range(1, 3),
                      ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1,
                      $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) drive(1'b0, 1'b1, 1'b0, $urandom);
        end
        idle(3);
        chk("cnt_random", 64'(O_line_cnt), 64'(m_cnt));

        // async reset while in phase 3, with a nonzero count
        send_line(5, 2, -1, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b1, $urandom);
        @(negedge I_clk);
        #1;
        I_rst_n = 1'b0;
        #1;
        chk_all_zero("midline_rst");
        chk("q_empty_at_rst", 64'(pix_q.size() + le_q.size()), 64'd0);
        I_csi_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge I_clk);
        I_rst_n = 1'b1;
        send_line(5, 2, -1, 1'b0);
        send_line(3, 2, -1, 1'b0);

        // counter wrap 4095 -> 0
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 4096; k++) send_line(1, 1, -1, 1'b0);
        idle(2);
        chk("cnt_wrap", 64'(O_line_cnt), 64'd0);

        idle(5);
        chk("pix_q_drained", 64'(pix_q.size()), 64'd0);
        chk("le_q_drained", 64'(le_q.size()), 64'd0);
        chk("fs_q_drained", 64'(fs_q.size()), 64'd0);
        chk("fe_q_drained", 64'(fe_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
